// File: rtl/shrink_queue_v2.sv
// Width-down converter: buffers wide beats in a DEPTH-entry ring and emits
// them as a stream of narrow words, honouring per-beat word counts and last.
module shrink_queue_v2 #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 32,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 0,
  localparam int MAX      = IN_WIDTH / OUT_WIDTH,
  localparam int CW       = $clog2(MAX + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic [CW-1:0]        din_words,
  input  logic                 din_last,
  input  logic                 vld_in,
  output logic                 rdy_upward,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_last,
  output logic                 vld_out,
  input  logic                 rdy_downward
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, STREAM} state_t;

  logic [IN_WIDTH-1:0] mem_data  [DEPTH];
  logic [CW-1:0]       mem_words [DEPTH];
  logic                mem_last  [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic [CW-1:0] idx;
  logic          rdy_en;
  state_t        state, state_next;

  logic          push, pop, xfer, word_end;
  logic [CW-1:0] words_norm, head_words, sel;

  // rdy_en holds rdy_upward low during reset and until the first clock after release
  assign rdy_upward = rdy_en && (count != NW'(DEPTH));
  assign push       = vld_in && rdy_upward;
  assign head_words = mem_words[rd_ptr];
  assign word_end   = (idx == head_words - 1'b1);
  assign xfer       = vld_out && rdy_downward;
  assign pop        = xfer && word_end;
  assign words_norm = (din_words == '0 || din_words > CW'(MAX)) ? CW'(MAX) : din_words;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i]  <= '0;
        mem_words[i] <= '0;
        mem_last[i]  <= 1'b0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      idx    <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) begin
        mem_data[wr_ptr]  <= din;
        mem_words[wr_ptr] <= words_norm;
        mem_last[wr_ptr]  <= din_last;
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (xfer) begin
        idx <= word_end ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (push) state_next = STREAM;
      STREAM:  if (pop && !push && count == NW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel       = (MSB_FIRST != 0) ? (CW'(MAX - 1) - idx) : idx;
    vld_out   = (count != '0);
    dout      = mem_data[rd_ptr][sel*OUT_WIDTH +: OUT_WIDTH];
    dout_last = vld_out && mem_last[rd_ptr] && word_end;
  end

endmodule

// File: tb/tb_shrink_queue_v2.sv
// Directed bench for shrink_queue_v2: one LSB-first DEPTH=2 instance and one
// MSB-first instance share the same stimulus.
module tb_shrink_queue_v2;

  localparam int IW = 512;
  localparam int OW = 32;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] din;
  logic [CW-1:0] din_words;
  logic          din_last;
  logic          vld_in;
  logic          rdy_downward;

  logic          rdy_upward, dout_last, vld_out;
  logic [OW-1:0] dout;
  logic          rdy_upward_b, dout_last_b, vld_out_b;
  logic [OW-1:0] dout_b;

  int n_vec = 0;
  int n_err = 0;

  shrink_queue_v2 #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(2), .MSB_FIRST(0)) dut (
    .clk(clk), .reset(reset), .din(din), .din_words(din_words), .din_last(din_last),
    .vld_in(vld_in), .rdy_upward(rdy_upward), .dout(dout), .dout_last(dout_last),
    .vld_out(vld_out), .rdy_downward(rdy_downward)
  );

  shrink_queue_v2 #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(2), .MSB_FIRST(1)) dut_b (
    .clk(clk), .reset(reset), .din(din), .din_words(din_words), .din_last(din_last),
    .vld_in(vld_in), .rdy_upward(rdy_upward_b), .dout(dout_b), .dout_last(dout_last_b),
    .vld_out(vld_out_b), .rdy_downward(rdy_downward)
  );

  always #5 clk = ~clk;

  // Word j of the returned beat carries base + j
  function automatic logic [IW-1:0] make_beat(input int base);
    logic [IW-1:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[j*OW +: OW] = OW'(base + j);
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    vld_in = 1'b0;
    rdy_downward = 1'b0;
    din = '0;
    din_words = '0;
    din_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    vld_in = 1'b0;
    rdy_downward = 1'b0;
    #2;
    n_vec++; if (vld_out !== 1'b0) begin n_err++; $display("[TB] FAIL reset_vld_out: got %b expected 0", vld_out); end
    n_vec++; if (dout !== '0) begin n_err++; $display("[TB] FAIL reset_dout: got %h expected 0", dout); end
    n_vec++; if (dout_last !== 1'b0) begin n_err++; $display("[TB] FAIL reset_dout_last: got %b expected 0", dout_last); end
    n_vec++; if (rdy_upward !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rdy_upward: got %b expected 0", rdy_upward); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++; if (rdy_upward !== 1'b0) begin n_err++; $display("[TB] FAIL release_rdy_before_edge: got %b expected 0", rdy_upward); end
    @(negedge clk);
    n_vec++; if (rdy_upward !== 1'b1) begin n_err++; $display("[TB] FAIL release_rdy_after_edge: got %b expected 1", rdy_upward); end
    n_vec++; if (vld_out !== 1'b0) begin n_err++; $display("[TB] FAIL release_vld_out: got %b expected 0", vld_out); end
  endtask

  task automatic test_basic_split();
    apply_reset();
    vld_in = 1'b1;
    din = make_beat(0);
    din_words = '0;
    din_last = 1'b1;
    rdy_downward = 1'b1;
    @(negedge clk);
    vld_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (vld_out !== 1'b1) begin n_err++; $display("[TB] FAIL basic_vld_w%0d: got %b expected 1", i, vld_out); end
      n_vec++; if (dout !== OW'(i)) begin n_err++; $display("[TB] FAIL basic_dout_w%0d: got %h expected %h", i, dout, i); end
      n_vec++; if (dout_last !== (i == 15)) begin n_err++; $display("[TB] FAIL basic_last_w%0d: got %b expected %b", i, dout_last, (i == 15)); end
      @(negedge clk);
    end
    n_vec++; if (vld_out !== 1'b0) begin n_err++; $display("[TB] FAIL basic_vld_after: got %b expected 0", vld_out); end
  endtask

  task automatic test_back_to_back();
    int mcount = 0;
    int pushed = 0;
    int got = 0;
    int cyc = 0;
    bit push, pop;
    apply_reset();
    rdy_downward = 1'b1;
    while (got < 64 && cyc < 200) begin
      cyc++;
      n_vec++; if (rdy_upward !== (mcount != 2)) begin n_err++; $display("[TB] FAIL b2b_rdy_up c%0d: got %b expected %b", cyc, rdy_upward, (mcount != 2)); end
      if (pushed > 0) begin
        n_vec++; if (vld_out !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_gap w%0d: got vld %b expected 1", got, vld_out); end
        n_vec++; if (dout !== OW'(((got / 16) << 8) + (got % 16))) begin n_err++; $display("[TB] FAIL b2b_dout w%0d: got %h expected %h", got, dout, ((got / 16) << 8) + (got % 16)); end
        n_vec++; if (dout_last !== (got == 63)) begin n_err++; $display("[TB] FAIL b2b_last w%0d: got %b expected %b", got, dout_last, (got == 63)); end
      end
      push = (mcount != 2) && (pushed < 4);
      vld_in = push;
      din = make_beat(pushed << 8);
      din_words = '0;
      din_last = (pushed == 3);
      pop = (mcount != 0) && (got % 16 == 15);
      if (mcount != 0) got++;
      mcount = mcount + int'(push) - int'(pop);
      if (push) pushed++;
      @(negedge clk);
    end
    vld_in = 1'b0;
    n_vec++; if (got != 64) begin n_err++; $display("[TB] FAIL b2b_timeout: got %0d words expected 64", got); end
    n_vec++; if (vld_out !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_drain: got vld %b expected 0", vld_out); end
  endtask

  task automatic test_partial_order();
    logic [IW-1:0] b0, b1;
    logic [OW-1:0] exp_d [4] = '{32'hA, 32'hB, 32'hC, 32'h55};
    bit exp_l [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    b0 = make_beat(32'h700);
    b0[IW-1 -: OW] = 32'hA;
    b0[IW-OW-1 -: OW] = 32'hB;
    b0[IW-2*OW-1 -: OW] = 32'hC;
    b1 = make_beat(32'h900);
    b1[IW-1 -: OW] = 32'h55;
    rdy_downward = 1'b1;
    vld_in = 1'b1;
    din = b0;
    din_words = 5'd3;
    din_last = 1'b1;
    @(negedge clk);
    din = b1;
    din_words = 5'd1;
    din_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (vld_out_b !== 1'b1) begin n_err++; $display("[TB] FAIL msb_vld_w%0d: got %b expected 1", i, vld_out_b); end
      n_vec++; if (dout_b !== exp_d[i]) begin n_err++; $display("[TB] FAIL msb_dout_w%0d: got %h expected %h", i, dout_b, exp_d[i]); end
      n_vec++; if (dout_last_b !== exp_l[i]) begin n_err++; $display("[TB] FAIL msb_last_w%0d: got %b expected %b", i, dout_last_b, exp_l[i]); end
      @(negedge clk);
      vld_in = 1'b0;
    end
    n_vec++; if (vld_out_b !== 1'b0) begin n_err++; $display("[TB] FAIL msb_vld_after: got %b expected 0", vld_out_b); end
  endtask

  task automatic test_backpressure();
    int bw [8] = '{16, 3, 1, 5, 0, 2, 7, 16};
    int mcount = 0;
    int pushed = 0;
    int hb = 0;
    int mi = 0;
    int cyc = 0;
    int ew;
    bit push, pop, stalled;
    logic [OW-1:0] prev_dout;
    stalled = 1'b0;
    prev_dout = '0;
    apply_reset();
    while (hb < 8 && cyc < 400) begin
      cyc++;
      n_vec++; if (rdy_upward !== (mcount != 2)) begin n_err++; $display("[TB] FAIL bp_rdy_up c%0d: got %b expected %b", cyc, rdy_upward, (mcount != 2)); end
      n_vec++; if (vld_out !== (mcount != 0)) begin n_err++; $display("[TB] FAIL bp_vld c%0d: got %b expected %b", cyc, vld_out, (mcount != 0)); end
      ew = (bw[hb] == 0) ? 16 : bw[hb];
      if (mcount != 0) begin
        n_vec++; if (dout !== OW'((hb << 8) + mi)) begin n_err++; $display("[TB] FAIL bp_dout b%0d w%0d: got %h expected %h", hb, mi, dout, (hb << 8) + mi); end
        n_vec++; if (dout_last !== ((hb % 2 == 1) && (mi == ew - 1))) begin n_err++; $display("[TB] FAIL bp_last b%0d w%0d: got %b", hb, mi, dout_last); end
        if (stalled) begin
          n_vec++; if (dout !== prev_dout) begin n_err++; $display("[TB] FAIL bp_stable c%0d: got %h expected %h", cyc, dout, prev_dout); end
        end
      end
      push = (mcount != 2) && (pushed < 8);
      vld_in = push;
      din = make_beat(pushed << 8);
      din_words = (pushed < 8) ? CW'(bw[pushed]) : '0;
      din_last = (pushed % 2 == 1);
      rdy_downward = 1'($urandom_range(0, 1));
      pop = 1'b0;
      stalled = 1'b0;
      if (mcount != 0) begin
        prev_dout = dout;
        if (rdy_downward) begin
          if (mi == ew - 1) begin
            mi = 0;
            hb++;
            pop = 1'b1;
          end else begin
            mi++;
          end
        end else begin
          stalled = 1'b1;
        end
      end
      mcount = mcount + int'(push) - int'(pop);
      if (push) pushed++;
      @(negedge clk);
    end
    vld_in = 1'b0;
    rdy_downward = 1'b0;
    n_vec++; if (hb != 8) begin n_err++; $display("[TB] FAIL bp_timeout: got %0d beats expected 8", hb); end
    n_vec++; if (vld_out !== 1'b0) begin n_err++; $display("[TB] FAIL bp_drain: got vld %b expected 0", vld_out); end
  endtask

  task automatic test_full_refusal();
    apply_reset();
    rdy_downward = 1'b0;
    vld_in = 1'b1;
    din_words = 5'd1;
    din_last = 1'b0;
    din = make_beat(32'h11);
    @(negedge clk);
    din = make_beat(32'h22);
    @(negedge clk);
    n_vec++; if (rdy_upward !== 1'b0) begin n_err++; $display("[TB] FAIL full_rdy_up: got %b expected 0", rdy_upward); end
    n_vec++; if (dout !== 32'h11) begin n_err++; $display("[TB] FAIL full_head: got %h expected 11", dout); end
    din = make_beat(32'h33);
    rdy_downward = 1'b1;
    @(negedge clk);
    n_vec++; if (rdy_upward !== 1'b1) begin n_err++; $display("[TB] FAIL full_rdy_next: got %b expected 1", rdy_upward); end
    n_vec++; if (dout !== 32'h22) begin n_err++; $display("[TB] FAIL full_second: got %h expected 22", dout); end
    @(negedge clk);
    vld_in = 1'b0;
    n_vec++; if (dout !== 32'h33 || vld_out !== 1'b1) begin n_err++; $display("[TB] FAIL full_third: got %h vld %b expected 33 vld 1", dout, vld_out); end
    n_vec++; if (rdy_upward !== 1'b1) begin n_err++; $display("[TB] FAIL full_rdy_one: got %b expected 1", rdy_upward); end
    @(negedge clk);
    n_vec++; if (vld_out !== 1'b0) begin n_err++; $display("[TB] FAIL full_no_dup: got vld %b dout %h expected vld 0", vld_out, dout); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    rdy_downward = 1'b1;
    vld_in = 1'b1;
    din = make_beat(0);
    din_words = '0;
    din_last = 1'b1;
    @(negedge clk);
    vld_in = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    n_vec++; if (dout !== 32'd5) begin n_err++; $display("[TB] FAIL areset_pre_word: got %h expected 5", dout); end
    #2;
    reset = 1'b0;
    #1;
    n_vec++; if (vld_out !== 1'b0) begin n_err++; $display("[TB] FAIL areset_vld: got %b expected 0", vld_out); end
    n_vec++; if (rdy_upward !== 1'b0) begin n_err++; $display("[TB] FAIL areset_rdy: got %b expected 0", rdy_upward); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (vld_out !== 1'b0) begin n_err++; $display("[TB] FAIL areset_stale: got %b expected 0", vld_out); end
    vld_in = 1'b1;
    din = make_beat(32'h100);
    @(negedge clk);
    vld_in = 1'b0;
    n_vec++; if (dout !== 32'h100 || vld_out !== 1'b1) begin n_err++; $display("[TB] FAIL areset_new_w0: got %h vld %b expected 100 vld 1", dout, vld_out); end
    @(negedge clk);
    n_vec++; if (dout !== 32'h101) begin n_err++; $display("[TB] FAIL areset_new_w1: got %h expected 101", dout); end
  endtask

  initial begin
    reset = 1'b1;
    vld_in = 1'b0;
    rdy_downward = 1'b0;
    din = '0;
    din_words = '0;
    din_last = 1'b0;
    test_reset();
    test_basic_split();
    test_back_to_back();
    test_partial_order();
    test_backpressure();
    test_full_refusal();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
